// File: rtl/service_gate_sequencer.sv
// Register-transfer gate sequencer: turns one accepted transfer request into a
// timed CLEAR -> READ -> WRITE train of one-hot gates, with a persistent carry-in flop.
module service_gate_sequencer #(
   parameter int unsigned NREG   = 8,
   parameter int unsigned ADDRW  = 3,
   parameter int unsigned U_IDX  = 6,
   parameter int unsigned CHBASE = 0
) (
   input  logic             SIM_CLK,
   input  logic             SIM_RST,
   input  logic             start,
   output logic             ready,
   input  logic [ADDRW-1:0] rd_sel,
   input  logic [ADDRW-1:0] wr_sel,
   input  logic             use_chan,
   input  logic [ADDRW-1:0] chan_addr,
   input  logic [1:0]       wmode,
   input  logic             ci_req,
   input  logic             ci_norm,
   input  logic             ginh,
   output logic [NREG-1:0]  clr_gate,
   output logic [NREG-1:0]  rd_gate,
   output logic [NREG-1:0]  wr_gate,
   output logic [3:0]       wm_gate,
   output logic             ci_gate,
   output logic             ciff,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {StIdle, StClr, StRd, StWr} state_e;

   state_e           state_q, state_d;
   logic [ADDRW-1:0] src_q, src_d;
   logic [ADDRW-1:0] dst_q, dst_d;
   logic [1:0]       wmode_q, wmode_d;
   logic             ciff_q, ciff_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [NREG-1:0]  clr_q, clr_d;
   logic [NREG-1:0]  rd_q, rd_d;
   logic [NREG-1:0]  wr_q, wr_d;
   logic [3:0]       wm_q, wm_d;

   // One extra bit so a channel address past the top of the file cannot wrap back in.
   logic [ADDRW:0]   dest_full;
   logic [31:0]      dest_w;
   logic [31:0]      src_w;
   logic             range_ok;

   function automatic logic [NREG-1:0] dec(input logic [ADDRW-1:0] idx);
      logic [NREG-1:0] oh;
      oh = '0;
      for (int i = 0; i < int'(NREG); i++) begin
         if (idx == ADDRW'(i)) oh[i] = 1'b1;
      end
      return oh;
   endfunction

   always_comb begin
      dest_full = use_chan ? ({1'b0, chan_addr} + (ADDRW+1)'(CHBASE)) : {1'b0, wr_sel};
      dest_w    = 32'(dest_full);
      src_w     = 32'(rd_sel);
      range_ok  = (dest_w < NREG) && (src_w < NREG);
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      wmode_d = wmode_q;
      ciff_d  = ciff_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      clr_d   = '0;
      rd_d    = '0;
      wr_d    = '0;
      wm_d    = '0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (range_ok) begin
                  state_d = StClr;
                  src_d   = rd_sel;
                  dst_d   = dest_full[ADDRW-1:0];
                  wmode_d = wmode;
                  clr_d   = dec(dest_full[ADDRW-1:0]);
                  if (ci_req) ciff_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StClr: begin
            state_d = StRd;
            rd_d    = dec(src_q);
         end
         StRd: begin
            state_d = StWr;
            wr_d    = ginh ? '0 : dec(dst_q);
            wm_d    = 4'b0001 << wmode_q;
            done_d  = 1'b1;
         end
         StWr: begin
            state_d = StIdle;
            // Only a write that actually reached the adder register consumes the carry.
            if ((32'(dst_q) == U_IDX) && (wr_q != '0)) ciff_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase
      ready_d = (state_d == StIdle);
   end

   always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) begin
         state_q <= StIdle;
         src_q   <= '0;
         dst_q   <= '0;
         wmode_q <= '0;
         ciff_q  <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         clr_q   <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         wm_q    <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         wmode_q <= wmode_d;
         ciff_q  <= ciff_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         err_q   <= err_d;
         clr_q   <= clr_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         wm_q    <= wm_d;
      end
   end

   assign ready    = ready_q;
   assign clr_gate = clr_q;
   assign rd_gate  = rd_q;
   assign wr_gate  = wr_q;
   assign wm_gate  = wm_q;
   assign ciff     = ciff_q;
   assign done     = done_q;
   assign err      = err_q;
   assign ci_gate  = (state_q == StWr) && (ciff_q || ci_norm);

endmodule

// File: tb/tb_service_gate_sequencer.sv
// Bench for service_gate_sequencer: a default 8-register instance with a transfer
// scoreboard, and a 6-register instance for rejection and top-index cases.
module tb_service_gate_sequencer;

   logic       SIM_CLK = 1'b0;
   logic       SIM_RST = 1'b1;
   logic       start = 1'b0, start_b = 1'b0;
   logic [2:0] rd_sel = '0, wr_sel = '0, chan_addr = '0;
   logic       use_chan = 1'b0, ci_req = 1'b0, ci_norm = 1'b0, ginh = 1'b0;
   logic [1:0] wmode = '0;

   logic       ready_a, ci_a, ciff_a, done_a, err_a;
   logic [7:0] clr_a, rd_a, wr_a;
   logic [3:0] wm_a;
   logic       ready_b, ci_b, ciff_b, done_b, err_b;
   logic [5:0] clr_b, rd_b, wr_b;
   logic [3:0] wm_b;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [7:0] clr;
      logic [7:0] rd;
      logic [7:0] wr;
      logic [3:0] wm;
      logic       ci;
   } exp_t;
   exp_t       sbq[$];
   logic [7:0] seen_clr = '0, seen_rd = '0;

   always #5 SIM_CLK = ~SIM_CLK;

   service_gate_sequencer #(.NREG(8), .ADDRW(3), .U_IDX(6), .CHBASE(0)) dut_a (
      .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .start(start), .ready(ready_a),
      .rd_sel(rd_sel), .wr_sel(wr_sel), .use_chan(use_chan), .chan_addr(chan_addr),
      .wmode(wmode), .ci_req(ci_req), .ci_norm(ci_norm), .ginh(ginh),
      .clr_gate(clr_a), .rd_gate(rd_a), .wr_gate(wr_a), .wm_gate(wm_a),
      .ci_gate(ci_a), .ciff(ciff_a), .done(done_a), .err(err_a)
   );

   service_gate_sequencer #(.NREG(6), .ADDRW(3), .U_IDX(4), .CHBASE(0)) dut_b (
      .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .start(start_b), .ready(ready_b),
      .rd_sel(rd_sel), .wr_sel(wr_sel), .use_chan(use_chan), .chan_addr(chan_addr),
      .wmode(wmode), .ci_req(ci_req), .ci_norm(ci_norm), .ginh(ginh),
      .clr_gate(clr_b), .rd_gate(rd_b), .wr_gate(wr_b), .wm_gate(wm_b),
      .ci_gate(ci_b), .ciff(ciff_b), .done(done_b), .err(err_b)
   );

   // Scoreboard monitor for dut_a: exclusivity every cycle, full transfer check on done.
   always @(negedge SIM_CLK) begin
      if (SIM_RST) begin
         sbq.delete();
         seen_clr = '0;
         seen_rd  = '0;
      end else begin
         n_tests++;
         if (($countones(clr_a) + $countones(rd_a) + $countones(wr_a)) > 1) begin
            n_fail++;
            $display("FAIL exclusive: clr=%h rd=%h wr=%h want at most one bit", clr_a, rd_a, wr_a);
         end
         if (clr_a != '0) seen_clr = clr_a;
         if (rd_a != '0) seen_rd = rd_a;
         if (done_a === 1'b1) begin
            n_tests++;
            if (sbq.size() == 0) begin
               n_fail++;
               $display("FAIL sb_empty: done seen with no expected transfer");
            end else begin
               exp_t e;
               e = sbq.pop_front();
               n_tests += 4;
               if (seen_clr !== e.clr) begin
                  n_fail++; $display("FAIL sb_clr: got %h want %h", seen_clr, e.clr);
               end
               if (seen_rd !== e.rd) begin
                  n_fail++; $display("FAIL sb_rd: got %h want %h", seen_rd, e.rd);
               end
               if ({wr_a, wm_a} !== {e.wr, e.wm}) begin
                  n_fail++; $display("FAIL sb_wr: got %h/%b want %h/%b", wr_a, wm_a, e.wr, e.wm);
               end
               if (ci_a !== e.ci) begin
                  n_fail++; $display("FAIL sb_ci: got %b want %b", ci_a, e.ci);
               end
            end
            seen_clr = '0;
            seen_rd  = '0;
         end
      end
   end

   task automatic step();
      @(posedge SIM_CLK);
      #1;
   endtask

   // Drives one request on dut_a across its accept edge and records the expected transfer.
   task automatic issue(input logic [2:0] rs, input logic [2:0] ws, input logic [1:0] wm,
                        input logic cr, input exp_t e);
      rd_sel = rs; wr_sel = ws; wmode = wm; ci_req = cr; start = 1'b1;
      sbq.push_back(e);
      step();
      start = 1'b0; ci_req = 1'b0;
   endtask

   task automatic test_reset();
      SIM_RST = 1'b1;
      step(); step();
      n_tests += 3;
      if ({ready_a, ready_b} !== 2'b11) begin
         n_fail++; $display("FAIL rst_ready: got %b want 11", {ready_a, ready_b});
      end
      if ({clr_a, rd_a, wr_a, wm_a} !== '0) begin
         n_fail++; $display("FAIL rst_gates: got %h want 0", {clr_a, rd_a, wr_a, wm_a});
      end
      if ({ci_a, ciff_a, done_a, err_a} !== 4'b0) begin
         n_fail++; $display("FAIL rst_flags: got %b want 0000", {ci_a, ciff_a, done_a, err_a});
      end
      SIM_RST = 1'b0;
      step();
   endtask

   task automatic test_normal();
      issue(3'd1, 3'd3, 2'd0, 1'b0, '{8'h08, 8'h02, 8'h08, 4'b0001, 1'b0});
      n_tests += 5;
      if ({clr_a, rd_a, ready_a} !== {8'h08, 8'h00, 1'b0}) begin
         n_fail++; $display("FAIL norm_clr: got %h/%h/%b want 08/00/0", clr_a, rd_a, ready_a);
      end
      step();
      if ({clr_a, rd_a} !== {8'h00, 8'h02}) begin
         n_fail++; $display("FAIL norm_rd: got %h/%h want 00/02", clr_a, rd_a);
      end
      step();
      if ({wr_a, wm_a, done_a} !== {8'h08, 4'b0001, 1'b1}) begin
         n_fail++; $display("FAIL norm_wr: got %h/%b/%b want 08/0001/1", wr_a, wm_a, done_a);
      end
      if (ready_a !== 1'b0) begin
         n_fail++; $display("FAIL norm_busy: got %b want 0", ready_a);
      end
      step();
      if ({ready_a, done_a, wr_a} !== {1'b1, 1'b0, 8'h00}) begin
         n_fail++; $display("FAIL norm_idle: got %b/%b/%h want 1/0/00", ready_a, done_a, wr_a);
      end
   endtask

   task automatic test_reset_mid();
      issue(3'd2, 3'd5, 2'd0, 1'b1, '{8'h20, 8'h04, 8'h20, 4'b0001, 1'b1});
      step();
      SIM_RST = 1'b1;
      step();
      SIM_RST = 1'b0;
      n_tests += 2;
      if ({clr_a, rd_a, wr_a, wm_a, done_a} !== '0) begin
         n_fail++; $display("FAIL midrst_gates: got %h want 0", {clr_a, rd_a, wr_a, wm_a, done_a});
      end
      if ({ready_a, ciff_a} !== 2'b10) begin
         n_fail++; $display("FAIL midrst_state: got %b want 10", {ready_a, ciff_a});
      end
      step(); step(); step();
   endtask

   task automatic test_channel();
      use_chan = 1'b1; chan_addr = 3'd4;
      issue(3'd0, 3'd1, 2'd2, 1'b0, '{8'h10, 8'h01, 8'h10, 4'b0100, 1'b0});
      n_tests += 2;
      if (clr_a !== 8'h10) begin
         n_fail++; $display("FAIL chan_clr: got %h want 10", clr_a);
      end
      step(); step();
      if ({wr_a, wm_a} !== {8'h10, 4'b0100}) begin
         n_fail++; $display("FAIL chan_wr: got %h/%b want 10/0100", wr_a, wm_a);
      end
      step();
      use_chan = 1'b0;
   endtask

   task automatic test_reject();
      // Channel 7 on a 6-register file, then an out-of-range source.
      for (int k = 0; k < 2; k++) begin
         use_chan = (k == 0); chan_addr = 3'd7; rd_sel = (k == 0) ? 3'd0 : 3'd6; wr_sel = 3'd1;
         start_b = 1'b1;
         step();
         start_b = 1'b0;
         n_tests += 2;
         if ({err_b, ready_b} !== 2'b11) begin
            n_fail++; $display("FAIL rej_err%0d: got %b want 11", k, {err_b, ready_b});
         end
         step();
         if ({err_b, clr_b, rd_b, wr_b, done_b} !== '0) begin
            n_fail++; $display("FAIL rej_quiet%0d: got %h want 0", k, {err_b, clr_b, rd_b, wr_b});
         end
         step();
      end
      use_chan = 1'b0;
      // Top register as both source and destination stays in separate phases.
      rd_sel = 3'd5; wr_sel = 3'd5; start_b = 1'b1;
      step();
      start_b = 1'b0;
      n_tests += 3;
      if ({clr_b, rd_b} !== {6'h20, 6'h00}) begin
         n_fail++; $display("FAIL top_clr: got %h/%h want 20/00", clr_b, rd_b);
      end
      step();
      if ({clr_b, rd_b} !== {6'h00, 6'h20}) begin
         n_fail++; $display("FAIL top_rd: got %h/%h want 00/20", clr_b, rd_b);
      end
      step();
      if ({wr_b, done_b, err_b} !== {6'h20, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL top_wr: got %h/%b/%b want 20/1/0", wr_b, done_b, err_b);
      end
      step();
   endtask

   task automatic test_carry();
      issue(3'd0, 3'd2, 2'd1, 1'b1, '{8'h04, 8'h01, 8'h04, 4'b0010, 1'b1});
      n_tests += 9;
      if (ciff_a !== 1'b1) begin
         n_fail++; $display("FAIL ci_set: got %b want 1", ciff_a);
      end
      step(); step();
      if (ci_a !== 1'b1) begin
         n_fail++; $display("FAIL ci_gate1: got %b want 1", ci_a);
      end
      step();
      if (ciff_a !== 1'b1) begin
         n_fail++; $display("FAIL ci_hold: got %b want 1", ciff_a);
      end
      issue(3'd1, 3'd6, 2'd0, 1'b0, '{8'h40, 8'h02, 8'h40, 4'b0001, 1'b1});
      step(); step();
      if (ci_a !== 1'b1) begin
         n_fail++; $display("FAIL ci_gate_u: got %b want 1", ci_a);
      end
      step();
      if (ciff_a !== 1'b0) begin
         n_fail++; $display("FAIL ci_clear: got %b want 0", ciff_a);
      end
      issue(3'd2, 3'd6, 2'd0, 1'b0, '{8'h40, 8'h04, 8'h40, 4'b0001, 1'b0});
      step(); step();
      if (ci_a !== 1'b0) begin
         n_fail++; $display("FAIL ci_off: got %b want 0", ci_a);
      end
      step();
      ci_norm = 1'b1;
      issue(3'd2, 3'd6, 2'd0, 1'b0, '{8'h40, 8'h04, 8'h40, 4'b0001, 1'b1});
      if (ci_a !== 1'b0) begin
         n_fail++; $display("FAIL ci_norm_clr: got %b want 0", ci_a);
      end
      step(); step();
      if (ci_a !== 1'b1) begin
         n_fail++; $display("FAIL ci_norm: got %b want 1", ci_a);
      end
      step();
      ci_norm = 1'b0;
      if (ciff_a !== 1'b0) begin
         n_fail++; $display("FAIL ci_norm_flop: got %b want 0", ciff_a);
      end
   endtask

   task automatic test_inhibit();
      ginh = 1'b1;
      issue(3'd3, 3'd6, 2'd3, 1'b1, '{8'h40, 8'h08, 8'h00, 4'b1000, 1'b1});
      n_tests += 4;
      if (clr_a !== 8'h40) begin
         n_fail++; $display("FAIL inh_clr: got %h want 40", clr_a);
      end
      step(); step();
      if ({wr_a, wm_a, done_a} !== {8'h00, 4'b1000, 1'b1}) begin
         n_fail++; $display("FAIL inh_wr: got %h/%b/%b want 00/1000/1", wr_a, wm_a, done_a);
      end
      step();
      ginh = 1'b0;
      if (ciff_a !== 1'b1) begin
         n_fail++; $display("FAIL inh_ciff: got %b want 1", ciff_a);
      end
      issue(3'd0, 3'd6, 2'd0, 1'b0, '{8'h40, 8'h01, 8'h40, 4'b0001, 1'b1});
      step(); step(); step();
      if (ciff_a !== 1'b0) begin
         n_fail++; $display("FAIL inh_release: got %b want 0", ciff_a);
      end
   endtask

   task automatic test_back_to_back();
      rd_sel = 3'd3; wr_sel = 3'd4; wmode = 2'd3; start = 1'b1;
      for (int j = 0; j < 3; j++) sbq.push_back('{8'h10, 8'h08, 8'h10, 4'b1000, 1'b0});
      for (int k = 1; k <= 12; k++) begin
         step();
         n_tests++;
         if ({done_a, clr_a != 8'h00, ready_a} !== {k % 4 == 3, k % 4 == 1, k % 4 == 0}) begin
            n_fail++;
            $display("FAIL b2b_c%0d: got done=%b clr=%h ready=%b", k, done_a, clr_a, ready_a);
         end
         if (k == 11) start = 1'b0;
      end
      step();
   endtask

   initial begin
      test_reset();
      test_normal();
      test_reset_mid();
      test_channel();
      test_reject();
      test_carry();
      test_inhibit();
      test_back_to_back();
      n_tests++;
      if (sbq.size() != 0) begin
         n_fail++; $display("FAIL sb_leftover: got %0d pending want 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/service_gate_sequencer.md
Name: service_gate_sequencer

Overview:
- Parametrised successor to the fixed service-gate decode.
- Takes one register-transfer request: source, destination, optional channel-addressed destination, write-shift mode and carry-in.
- Sequences it as a timed CLEAR → READ → WRITE gate train over one-hot register gate buses.
- Holds a carry-in flip-flop across transfers.
- Sits between the control-pulse decoder and the central register file / write bus.

Parameters:
- NREG, 8, number of gated registers (2..64).
- ADDRW, 3, register/channel address width; must satisfy 2**ADDRW >= NREG.
- U_IDX, 6, index of the adder-output register whose write consumes the carry-in flop.
- CHBASE, 0, register index that channel address 0 maps to.

Ports:
- SIM_CLK  in  1  system clock, all state on rising edge.
- SIM_RST  in  1  synchronous, active-high reset.
- start  in  1  request strobe; accepted only when ready=1.
- ready  out  1  sequencer idle, can accept start.
- rd_sel  in  ADDRW  source register index.
- wr_sel  in  ADDRW  destination register index (used when use_chan=0).
- use_chan  in  1  destination = CHBASE + chan_addr (channel-addressed write).
- chan_addr  in  ADDRW  channel address.
- wmode  in  2  write mode: 0 normal, 1 cycle-left, 2 cycle-right, 3 shift-right.
- ci_req  in  1  request carry-in for this and following adder writes.
- ci_norm  in  1  level; forces carry-in during WRITE regardless of flop.
- ginh  in  1  level; inhibits the write gate in WRITE phase (clear still occurs).
- clr_gate  out  NREG  one-hot clear gate.
- rd_gate  out  NREG  one-hot read gate.
- wr_gate  out  NREG  one-hot write gate.
- wm_gate  out  4  one-hot write-mode gate, valid with wr_gate.
- ci_gate  out  1  carry-in to adder.
- ciff  out  1  carry-in flop state.
- done  out  1  one-cycle pulse at end of WRITE.
- err  out  1  one-cycle pulse: rejected request.

Behaviour:
- Reset (SIM_RST=1 at clock edge):
  - State→IDLE.
  - All gate buses 0; ci_gate, ciff, done, err all 0; ready=1.
  - Reset overrides every other input, including mid-transfer.
  - A transfer in progress is abandoned with no done pulse.
- States: IDLE → CLR → RD → WR → IDLE. One cycle each, so a transfer takes 3 cycles after accept.
  - Back-to-back: ready is 1 in the cycle after WR; the next start is accepted then.
  - Minimum start-to-start spacing is 4 cycles.
- Accept: start & ready latches rd_sel, the resolved destination, wmode, and ginh-independent fields. Inputs are ignored while busy.
- Resolved destination:
  - use_chan ? CHBASE + chan_addr : wr_sel, computed at ADDRW+1 bits with no wrap.
  - If destination >= NREG or rd_sel >= NREG: request rejected, err pulses the next cycle, state stays IDLE, no gates.
- CLR: clr_gate[dest]=1, other gate buses 0.
- RD: rd_gate[src]=1.
- WR:
  - wr_gate[dest]=1 unless ginh=1 (ginh sampled in WR cycle).
  - wm_gate[wmode]=1 whenever WR, even if inhibited.
  - done=1.
  - Source equal to destination is legal; the gates remain in separate cycles.
- Carry flop ciff:
  - Set on the accept cycle when ci_req=1.
  - Cleared at the end of any WR whose dest==U_IDX and ginh=0.
  - If set and clear coincide (ci_req accepted in the same cycle as a clearing WR, impossible by timing), set wins.
- ci_gate = WR & (ciff | ci_norm), combinational from state and flops.
- At most one bit set across each gate bus; no two phases' gates overlap in a cycle.
- All outputs except ci_gate are registered.

Test Plan:
- Reset mid-transfer: accept rd_sel=2, wr_sel=5, assert SIM_RST during RD → next cycle all gates 0, ready=1, no done, ciff=0.
- Normal transfer: rd_sel=1, wr_sel=3, wmode=0 → clr_gate=0x08 at +1, rd_gate=0x02 at +2, wr_gate=0x08 with wm_gate=0001 and done at +3, ready at +4.
- Channel write: use_chan=1, chan_addr=4, CHBASE=0, wmode=2 → clr/wr_gate=0x10, wm_gate=0100. Repeat with chan_addr=7 and NREG=6 (ADDRW=3) → err pulse, no gates.
- Carry: ci_req=1 with dest=2 → ci_gate=1 in WR, ciff stays 1. Next transfer with dest=U_IDX=6 → ci_gate=1, ciff=0 after WR. Third transfer → ci_gate=0; with ci_norm=1 → ci_gate=1.
- Inhibit: ginh=1 during WR with dest=U_IDX, ciff=1 → clr_gate fired, wr_gate=0, done=1, ciff remains 1.
- Back-to-back: start held high continuously for 3 requests → accepts exactly at cycles 0, 4, 8; done at 3, 7, 11; gate buses never multi-hot.
